// File: rtl/rng_pkg.sv
// Shared types and helpers for the LFSR random-number source.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } rng_state_e;

    // Maximal-length Galois tap masks (right-shift form)
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [31:0] TAPS_W32 = 32'hA3000000;

    // Operates on a zero-extended state; callers truncate back to their width
    function automatic logic [31:0] galois_next(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR state register with seed load; a zero seed is replaced by SEED
// so the register can never lock up at zero.
module lfsr_galois
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] state_q;

    assign next  = WIDTH'(galois_next(32'(state_q), 32'(TAPS)));
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_q <= next;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Request/valid uniform draw engine on top of a Galois LFSR: rejection
// sampling into [0, RANGE-1], optional no-immediate-repeat, bounded retries.
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      RANGE     = 9,
    parameter bit               NO_REPEAT = 1'b1,
    parameter int unsigned      MAX_TRY   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             rdy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic [WIDTH-1:0] raw
);

    localparam int unsigned TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

    rng_state_e       state_q;
    logic [OUT_W-1:0] value_q;
    logic             have_prev_q;
    logic [TRY_W-1:0] try_cnt_q;

    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] unused_next;
    logic [OUT_W-1:0] cand;
    logic             cand_reject;
    logic             last_try;
    logic [31:0]      value_inc;
    logic [OUT_W-1:0] fallback;

    // Step when free-running in IDLE (req wins over en) or once per DRAW cycle
    assign lfsr_step = !seed_load &&
                       (((state_q == IDLE) && !req && en) || (state_q == DRAW));

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (lfsr_step),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state),
        .next     (lfsr_next)
    );

    assign unused_next = lfsr_next;
    assign cand        = lfsr_next[WIDTH-1 -: OUT_W];
    assign cand_reject = (32'(cand) >= RANGE) ||
                         (NO_REPEAT && have_prev_q && (cand == value_q));
    assign last_try    = (32'(try_cnt_q) == (MAX_TRY - 1));
    assign value_inc   = 32'(value_q) + 32'd1;
    assign fallback    = !have_prev_q        ? '0 :
                         (value_inc >= RANGE) ? '0 : OUT_W'(value_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            value_q     <= '0;
            have_prev_q <= 1'b0;
            try_cnt_q   <= '0;
        end else if (seed_load) begin
            state_q     <= IDLE;
            have_prev_q <= 1'b0;
            try_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q   <= DRAW;
                        try_cnt_q <= '0;
                    end
                end
                DRAW: begin
                    if (!cand_reject) begin
                        value_q <= cand;
                        state_q <= DONE;
                    end else if (last_try) begin
                        value_q <= fallback;
                        state_q <= DONE;
                    end else begin
                        try_cnt_q <= try_cnt_q + TRY_W'(1);
                    end
                end
                DONE: begin
                    have_prev_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdy   = (state_q == IDLE);
    assign valid = (state_q == DONE);
    assign value = value_q;
    assign raw   = lfsr_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed-vector and scoreboard bench for lfsr_rng (WIDTH=16, RANGE=9, MAX_TRY=4).
module tb_lfsr_rng;

    localparam int RNG = 9;
    localparam int MT  = 4;

    logic        clk = 1'b0;
    logic        rst, en, seed_load, req;
    logic [15:0] seed_in;
    logic        rdy, valid;
    logic [3:0]  value;
    logic [15:0] raw;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_rng #(
        .WIDTH     (16),
        .TAPS      (16'hB400),
        .SEED      (16'h0001),
        .OUT_W     (4),
        .RANGE     (RNG),
        .NO_REPEAT (1'b1),
        .MAX_TRY   (MT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .rdy       (rdy),
        .valid     (valid),
        .value     (value),
        .raw       (raw)
    );

    typedef enum {OP_LOAD, OP_EN, OP_DRAW} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] arg;
        logic        en_dur;
        int          exp_k;
        logic [3:0]  exp_val;
        logic [15:0] exp_raw;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
    endtask

    // Issue one req and wait (bounded) for valid; k = DRAW cycles taken
    task automatic do_draw(input logic en_dur, output int k, output logic [3:0] v);
        logic rdy_seen;
        req = 1'b1;
        en  = en_dur;
        tick();
        req      = 1'b0;
        k        = 0;
        rdy_seen = 1'b0;
        while (!valid && k < 20) begin
            if (rdy) rdy_seen = 1'b1;
            tick();
            k++;
        end
        check("draw_valid_seen", 32'(valid), 32'd1);
        check("rdy_low_in_draw", 32'(rdy_seen | rdy), 32'd0);
        v  = value;
        en = 1'b0;
        tick();
        check("valid_single_cycle", 32'(valid), 32'd0);
        check("rdy_back_idle", 32'(rdy), 32'd1);
        check("value_held", 32'(value), 32'(v));
    endtask

    initial begin
        int          k;
        logic [3:0]  v;
        logic [15:0] m_s;
        logic [3:0]  m_prev;
        logic        m_have;
        logic [3:0]  d_prev;
        logic        d_have;

        vecs[0] = '{OP_LOAD, 16'h0001, 1'b0, 0, 4'd0, 16'h0001};
        vecs[1] = '{OP_DRAW, 16'h0000, 1'b0, 2, 4'd5, 16'h5A00};
        vecs[2] = '{OP_DRAW, 16'h0000, 1'b1, 1, 4'd2, 16'h2D00};
        vecs[3] = '{OP_DRAW, 16'h0000, 1'b0, 1, 4'd1, 16'h1680};
        vecs[4] = '{OP_DRAW, 16'h0000, 1'b0, 1, 4'd0, 16'h0B40};
        vecs[5] = '{OP_DRAW, 16'h0000, 1'b0, 4, 4'd1, 16'h00B4};
        vecs[6] = '{OP_LOAD, 16'h0000, 1'b0, 0, 4'd0, 16'h0001};
        vecs[7] = '{OP_EN,   16'd3,    1'b0, 0, 4'd0, 16'h2D00};
        vecs[8] = '{OP_DRAW, 16'h0000, 1'b1, 1, 4'd1, 16'h1680};

        rst = 1'b1; en = 1'b0; seed_load = 1'b0; req = 1'b0; seed_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_raw", 32'(raw), 32'h0001);
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_value", 32'(value), 32'd0);

        for (int i = 0; i < 9; i++) begin
            case (vecs[i].op)
                OP_LOAD: begin
                    do_load(vecs[i].arg);
                    check("load_rdy", 32'(rdy), 32'd1);
                    check("load_valid", 32'(valid), 32'd0);
                end
                OP_EN: begin
                    en = 1'b1;
                    for (int j = 0; j < int'(vecs[i].arg); j++) tick();
                    en = 1'b0;
                end
                default: begin
                    do_draw(vecs[i].en_dur, k, v);
                    check("vec_latency", 32'(k), 32'(vecs[i].exp_k));
                    check("vec_value", 32'(v), 32'(vecs[i].exp_val));
                end
            endcase
            check("vec_raw", 32'(raw), 32'(vecs[i].exp_raw));
        end

        // Abort a draw mid-flight; previous value 1 must then be drawable again
        do_load(16'h0001);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("abort_in_draw", 32'(rdy), 32'd0);
        seed_load = 1'b1;
        seed_in   = 16'h2D00;
        tick();
        seed_load = 1'b0;
        check("abort_no_valid", 32'(valid), 32'd0);
        check("abort_idle", 32'(rdy), 32'd1);
        check("abort_raw", 32'(raw), 32'h2D00);
        tick();
        check("abort_no_valid_late", 32'(valid), 32'd0);
        do_draw(1'b0, k, v);
        check("abort_redraw_k", 32'(k), 32'd1);
        check("abort_redraw_value", 32'(v), 32'd1);
        check("abort_redraw_raw", 32'(raw), 32'h1680);

        // Scoreboard soak against an independent model
        do_load(16'hACE1);
        m_s = 16'hACE1; m_have = 1'b0; m_prev = '0; d_have = 1'b0; d_prev = '0;
        for (int it = 0; it < 1500; it++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                logic [15:0] s;
                s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                do_load(s);
                m_s    = (s == 16'h0000) ? 16'h0001 : s;
                m_have = 1'b0;
                d_have = 1'b0;
            end else if (sel < 5) begin
                int n;
                n  = int'($urandom_range(1, 5));
                en = 1'b1;
                for (int j = 0; j < n; j++) tick();
                en = 1'b0;
                for (int j = 0; j < n; j++) m_s = m_step(m_s);
            end else begin
                int         mk;
                logic [3:0] mv;
                logic       hit;
                mk  = 0;
                hit = 1'b0;
                mv  = '0;
                for (int t = 0; t < MT && !hit; t++) begin
                    logic [3:0] c;
                    m_s = m_step(m_s);
                    c   = m_s[15:12];
                    mk++;
                    if (!((int'(c) >= RNG) || (m_have && c == m_prev))) begin
                        mv  = c;
                        hit = 1'b1;
                    end
                end
                if (!hit) mv = m_have ? 4'((int'(m_prev) + 1) % RNG) : 4'd0;
                m_prev = mv;
                m_have = 1'b1;
                do_draw(1'($urandom_range(0, 1)), k, v);
                check("soak_latency", 32'(k), 32'(mk));
                check("soak_value", 32'(v), 32'(mv));
                check("soak_in_range", 32'(int'(v) < RNG), 32'd1);
                check("soak_no_repeat", 32'(d_have && v == d_prev), 32'd0);
                d_prev = v;
                d_have = 1'b1;
            end
            check("soak_raw", 32'(raw), 32'(m_s));
            check("soak_raw_nonzero", 32'(raw != 16'h0000), 32'd1);
        end

        // Full period: free-running from 0001 must come back after 65535 steps
        begin
            int   ret_at;
            logic saw_zero;
            do_load(16'h0001);
            ret_at   = 0;
            saw_zero = 1'b0;
            en       = 1'b1;
            for (int i = 1; i <= 65535; i++) begin
                tick();
                if (raw == 16'h0000) saw_zero = 1'b1;
                if (raw == 16'h0001 && ret_at == 0) ret_at = i;
            end
            en = 1'b0;
            check("period_length", 32'(ret_at), 32'd65535);
            check("period_no_zero", 32'(saw_zero), 32'd0);
            check("period_end_raw", 32'(raw), 32'h0001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
